// File: rtl/comparador_serial_ctrl_pkg.sv
// Shared definitions for the serial MSB-first magnitude comparator.
// Holds the controller state encoding and the start-acceptance rule.
package comparador_serial_ctrl_pkg;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] COMPARA = 2'd1;
    localparam logic [1:0] FIM     = 2'd2;

    // A new start is taken when idle or in the result cycle.
    function automatic logic aceita_inicio(
        input logic [1:0] st,
        input logic       ini
    );
        return ini && ((st == OCIOSO) || (st == FIM));
    endfunction

endpackage

// File: rtl/comparador_serial_ctrl_bit.sv
// Single-bit magnitude comparator used as the serial datapath slice.
// Purely combinational: exactly one output is high for any input pair.
module comparador1bit_behav (
    input  logic a,
    input  logic b,
    output logic maior,
    output logic menor,
    output logic igual
);

    always_comb begin
        maior = a & ~b;
        menor = ~a & b;
        igual = ~(a ^ b);
    end

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Serial N-bit unsigned comparator: one bit per clock, MSB first,
// stopping at the first differing bit and pulsing pronto with the result.
module comparador_serial_ctrl
    import comparador_serial_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inicio,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ocupado,
    output logic         pronto,
    output logic         maior,
    output logic         menor,
    output logic         igual
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          maior_q, maior_d;
    logic          menor_q, menor_d;
    logic          igual_q, igual_d;

    logic bit_maior;
    logic bit_menor;
    logic bit_igual;
    logic aceita;

    comparador1bit_behav u_bit (
        .a     (a_q[idx_q]),
        .b     (b_q[idx_q]),
        .maior (bit_maior),
        .menor (bit_menor),
        .igual (bit_igual)
    );

    assign aceita = aceita_inicio(state_q, inicio);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        maior_d = maior_q;
        menor_d = menor_q;
        igual_d = igual_q;
        case (state_q)
            OCIOSO, FIM: begin
                state_d = OCIOSO;
                if (aceita) begin
                    state_d = COMPARA;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_MAX;
                    maior_d = 1'b0;
                    menor_d = 1'b0;
                    igual_d = 1'b0;
                end
            end
            COMPARA: begin
                if (!bit_igual) begin
                    maior_d = bit_maior;
                    menor_d = bit_menor;
                    igual_d = 1'b0;
                    state_d = FIM;
                end else if (idx_q == '0) begin
                    // Reaching bit 0 with no difference means equality.
                    maior_d = 1'b0;
                    menor_d = 1'b0;
                    igual_d = 1'b1;
                    state_d = FIM;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCIOSO;
            idx_q   <= IDX_MAX;
            a_q     <= '0;
            b_q     <= '0;
            maior_q <= 1'b0;
            menor_q <= 1'b0;
            igual_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            maior_q <= maior_d;
            menor_q <= menor_d;
            igual_q <= igual_d;
        end
    end

    assign ocupado = (state_q == COMPARA);
    assign pronto  = (state_q == FIM);
    assign maior   = maior_q;
    assign menor   = menor_q;
    assign igual   = igual_q;

endmodule
